// File: rtl/mvm_uart_frame_ctrl.sv
`timescale 1ns/1ps
// Opcode-framed UART byte controller for the axis_matvec_mul core: resident K, X load, re-run, framed results.
// Optional build macro MVM_UART_SAT_EN: saturate narrowed results and flag it with header 0x5B.
module mvm_uart_frame_ctrl #(
    parameter int R              = 8,
    parameter int C              = 8,
    parameter int W_X            = 8,
    parameter int W_K            = 8,
    parameter int W_Y_OUT        = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           s_byte_valid,
    input  logic [7:0]                     s_byte_data,
    output logic                           s_byte_ready,
    output logic                           m_kx_valid,
    input  logic                           m_kx_ready,
    output logic [R*C*W_K+C*W_X-1:0]       m_kx_data,
    input  logic                           s_y_valid,
    output logic                           s_y_ready,
    input  logic [R*(W_X+W_K+$clog2(C))-1:0] s_y_data,
    output logic                           m_byte_valid,
    output logic [7:0]                     m_byte_data,
    input  logic                           m_byte_ready,
    output logic                           o_busy,
    output logic                           o_err
);
    localparam int W_Y    = W_X + W_K + $clog2(C);
    localparam int NB_K   = R * C * W_K / 8;
    localparam int NB_X   = C * W_X / 8;
    localparam int NB_Y   = R * W_Y_OUT / 8;
    localparam int NB_KX  = (NB_K > NB_X) ? NB_K : NB_X;
    localparam int NB_MAX = (NB_KX > NB_Y) ? NB_KX : NB_Y;
    localparam int CNT_W  = $clog2(NB_MAX + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OP_K   = 8'hA1;
    localparam logic [7:0] OP_X   = 8'hA2;
    localparam logic [7:0] OP_RUN = 8'hA3;
    localparam logic [7:0] HDR    = 8'h5A;
`ifdef MVM_UART_SAT_EN
    localparam logic [7:0] HDR_SAT = 8'h5B;

    function automatic logic f_is_sat(input logic signed [W_Y-1:0] v);
        logic signed [W_Y-1:0] sh;
        sh = v >>> (W_Y_OUT - 1);
        return (W_Y_OUT < W_Y) && (sh != '0) && (sh != '1);
    endfunction

    function automatic logic [W_Y_OUT-1:0] f_conv(input logic signed [W_Y-1:0] v);
        if (f_is_sat(v))
            return v[W_Y-1] ? {1'b1, {(W_Y_OUT-1){1'b0}}} : {1'b0, {(W_Y_OUT-1){1'b1}}};
        return W_Y_OUT'(v);
    endfunction
`else
    // Signed size cast sign-extends when widening and keeps the low bits when narrowing.
    function automatic logic [W_Y_OUT-1:0] f_conv(input logic signed [W_Y-1:0] v);
        return W_Y_OUT'(v);
    endfunction
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_RX_K, S_RX_X, S_ISSUE, S_WAIT_Y, S_TX_HDR, S_TX_DATA
    } state_t;

    state_t               r_state, w_next;
    logic [R*C*W_K-1:0]   r_k;
    logic [C*W_X-1:0]     r_x;
    logic [R*W_Y_OUT-1:0] r_y;
    logic [CNT_W-1:0]     r_cnt;
    logic [TMO_W-1:0]     r_tmo;
    logic                 r_err;
    logic                 w_byte_acc;
    logic                 w_op_ok;
    logic                 w_tmo_hit;
    logic [R*W_Y_OUT-1:0] w_y_conv;
`ifdef MVM_UART_SAT_EN
    logic                 r_sat;
    logic [R-1:0]         w_sat_el;
`endif

    for (genvar g = 0; g < R; g++) begin : g_conv
        assign w_y_conv[g*W_Y_OUT +: W_Y_OUT] = f_conv(s_y_data[g*W_Y +: W_Y]);
`ifdef MVM_UART_SAT_EN
        assign w_sat_el[g] = f_is_sat(s_y_data[g*W_Y +: W_Y]);
`endif
    end

    assign w_byte_acc = s_byte_valid && s_byte_ready;
    assign w_op_ok    = (s_byte_data == OP_K) || (s_byte_data == OP_X) || (s_byte_data == OP_RUN);
    assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign m_kx_data  = {r_x, r_k};
    assign o_busy     = (r_state != S_IDLE);
    assign o_err      = r_err;

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        s_byte_ready = 1'b0;
        m_kx_valid   = 1'b0;
        s_y_ready    = 1'b0;
        m_byte_valid = 1'b0;
        m_byte_data  = 8'h00;
        case (r_state)
            S_IDLE: begin
                s_byte_ready = 1'b1;
                if (s_byte_valid) begin
                    case (s_byte_data)
                        OP_K:    w_next = S_RX_K;
                        OP_X:    w_next = S_RX_X;
                        OP_RUN:  w_next = S_ISSUE;
                        default: w_next = S_IDLE;
                    endcase
                end
            end
            S_RX_K: begin
                s_byte_ready = 1'b1;
                if (s_byte_valid) begin
                    if (r_cnt == CNT_W'(NB_K - 1)) w_next = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_next = S_IDLE;
                end
            end
            S_RX_X: begin
                s_byte_ready = 1'b1;
                if (s_byte_valid) begin
                    if (r_cnt == CNT_W'(NB_X - 1)) w_next = S_ISSUE;
                end else if (w_tmo_hit) begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                m_kx_valid = 1'b1;
                if (m_kx_ready) w_next = S_WAIT_Y;
            end
            S_WAIT_Y: begin
                s_y_ready = 1'b1;
                if (s_y_valid) w_next = S_TX_HDR;
            end
            S_TX_HDR: begin
                m_byte_valid = 1'b1;
`ifdef MVM_UART_SAT_EN
                m_byte_data  = r_sat ? HDR_SAT : HDR;
`else
                m_byte_data  = HDR;
`endif
                if (m_byte_ready) w_next = S_TX_DATA;
            end
            S_TX_DATA: begin
                m_byte_valid = 1'b1;
                m_byte_data  = r_y[{r_cnt, 3'b000} +: 8];
                if (m_byte_ready && (r_cnt == CNT_W'(NB_Y - 1))) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Nothing is accepted while reset is held, even though the state reads IDLE.
        if (!rstn) s_byte_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_k   <= '0;
            r_x   <= '0;
            r_cnt <= '0;
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_byte_acc) begin
                        r_cnt <= '0;
                        r_tmo <= '0;
                        r_err <= !w_op_ok;
                    end
                end
                S_RX_K, S_RX_X: begin
                    if (w_byte_acc) begin
                        if (r_state == S_RX_K) r_k[{r_cnt, 3'b000} +: 8] <= s_byte_data;
                        else                   r_x[{r_cnt, 3'b000} +: 8] <= s_byte_data;
                        r_cnt <= r_cnt + 1'b1;
                        r_tmo <= '0;
                    end else if (w_tmo_hit) begin
                        r_tmo <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_WAIT_Y: begin
                    if (s_y_valid) r_cnt <= '0;
                end
                S_TX_DATA: begin
                    if (m_byte_ready) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result capture holds no control state, so it carries no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_WAIT_Y && s_y_valid) begin
            r_y   <= w_y_conv;
`ifdef MVM_UART_SAT_EN
            r_sat <= |w_sat_el;
`endif
        end
    end
endmodule

// File: tb/tb_mvm_uart_frame_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for mvm_uart_frame_ctrl: DUT A (R=C=2, 32-bit out) and DUT B (16-bit out, narrowing).
module tb_mvm_uart_frame_ctrl;
    localparam int W_KX = 48;
    localparam int W_YI = 34;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn = 1'b0;
    logic            sel = 1'b0;
    logic            s_byte_valid = 1'b0;
    logic [7:0]      s_byte_data = 8'h00;
    logic            m_kx_ready = 1'b0;
    logic            s_y_valid = 1'b0;
    logic [W_YI-1:0] s_y_data = '0;
    logic            m_byte_ready = 1'b0;

    logic            a_byte_rdy, a_kx_valid, a_y_rdy, a_tx_valid, a_busy, a_err;
    logic            b_byte_rdy, b_kx_valid, b_y_rdy, b_tx_valid, b_busy, b_err;
    logic [W_KX-1:0] a_kx_data, b_kx_data;
    logic [7:0]      a_tx_data, b_tx_data;

    logic            byte_rdy, kx_valid, y_rdy, tx_valid, busy, err;
    logic [W_KX-1:0] kx_data;
    logic [7:0]      tx_data;

    assign byte_rdy = sel ? b_byte_rdy : a_byte_rdy;
    assign kx_valid = sel ? b_kx_valid : a_kx_valid;
    assign kx_data  = sel ? b_kx_data  : a_kx_data;
    assign y_rdy    = sel ? b_y_rdy    : a_y_rdy;
    assign tx_valid = sel ? b_tx_valid : a_tx_valid;
    assign tx_data  = sel ? b_tx_data  : a_tx_data;
    assign busy     = sel ? b_busy     : a_busy;
    assign err      = sel ? b_err      : a_err;

    mvm_uart_frame_ctrl #(.R(2), .C(2), .W_X(8), .W_K(8), .W_Y_OUT(32), .TIMEOUT_CYCLES(100)) u_dut_a (
        .clk(clk), .rstn(rstn),
        .s_byte_valid(s_byte_valid && !sel), .s_byte_data(s_byte_data), .s_byte_ready(a_byte_rdy),
        .m_kx_valid(a_kx_valid), .m_kx_ready(m_kx_ready && !sel), .m_kx_data(a_kx_data),
        .s_y_valid(s_y_valid && !sel), .s_y_ready(a_y_rdy), .s_y_data(s_y_data),
        .m_byte_valid(a_tx_valid), .m_byte_data(a_tx_data), .m_byte_ready(m_byte_ready && !sel),
        .o_busy(a_busy), .o_err(a_err)
    );

    mvm_uart_frame_ctrl #(.R(2), .C(2), .W_X(8), .W_K(8), .W_Y_OUT(16), .TIMEOUT_CYCLES(100)) u_dut_b (
        .clk(clk), .rstn(rstn),
        .s_byte_valid(s_byte_valid && sel), .s_byte_data(s_byte_data), .s_byte_ready(b_byte_rdy),
        .m_kx_valid(b_kx_valid), .m_kx_ready(m_kx_ready && sel), .m_kx_data(b_kx_data),
        .s_y_valid(s_y_valid && sel), .s_y_ready(b_y_rdy), .s_y_data(s_y_data),
        .m_byte_valid(b_tx_valid), .m_byte_data(b_tx_data), .m_byte_ready(m_byte_ready && sel),
        .o_busy(b_busy), .o_err(b_err)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_byte_valid = 1'b1;
        s_byte_data  = b;
        while (!byte_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!byte_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_byte: ready never rose for byte %02h", b);
        end
        @(negedge clk);
        s_byte_valid = 1'b0;
    endtask

    task automatic push_y32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    task automatic push_y16(input logic [15:0] v);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(v[15:8]);
    endtask

    task automatic core_op(input logic [W_KX-1:0] exp_kx, input logic [W_YI-1:0] y);
        int n;
        n = 0;
        while (!kx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (kx_valid !== 1'b1 || kx_data !== exp_kx) begin
            errors++;
            $display("FAIL kx_data: got %h (valid %b), want %h", kx_data, kx_valid, exp_kx);
        end
        m_kx_ready = 1'b1;
        @(negedge clk);
        m_kx_ready = 1'b0;
        n = 0;
        while (!y_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (y_rdy !== 1'b1) begin
            errors++;
            $display("FAIL y_ready: got %b, want 1", y_rdy);
        end
        s_y_data  = y;
        s_y_valid = 1'b1;
        @(negedge clk);
        s_y_valid = 1'b0;
    endtask

    task automatic collect(input int nbytes, input int stall_idx);
        logic [7:0] e;
        int         t;
        int         bad;
        for (int i = 0; i < nbytes; i++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: no expected byte for index %0d", i);
                e = 8'h00;
            end else begin
                e = exp_q.pop_front();
            end
            m_byte_ready = (i != stall_idx);
            t = 0;
            while (!tx_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (i == stall_idx) begin
                bad = 0;
                for (int s = 0; s < 50; s++) begin
                    if (tx_valid !== 1'b1 || tx_data !== e) bad++;
                    @(negedge clk);
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL stall_hold: %0d unstable cycles, want 0 (byte %02h)", bad, e);
                end
                m_byte_ready = 1'b1;
            end
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== e) begin
                errors++;
                $display("FAIL tx_byte[%0d]: got %02h (valid %b), want %02h", i, tx_data, tx_valid, e);
            end
            @(negedge clk);
        end
        m_byte_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({byte_rdy, kx_valid, y_rdy, tx_valid, busy, err, tx_data} !== 14'h0 || kx_data !== '0) begin
            errors++;
            $display("FAIL %s: rdy=%b kxv=%b yrdy=%b txv=%b busy=%b err=%b tx=%02h kx=%h, want all 0",
                     tag, byte_rdy, kx_valid, y_rdy, tx_valid, busy, err, tx_data, kx_data);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (byte_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: ready=%b busy=%b, want 1/0", byte_rdy, busy);
        end
    endtask

    task automatic test_load_run();
        send_byte(8'hA1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        checks++;
        if (busy !== 1'b0 || kx_valid !== 1'b0) begin
            errors++;
            $display("FAIL k_load_idle: busy=%b kxv=%b, want 0/0", busy, kx_valid);
        end
        send_byte(8'hA2);
        send_byte(8'h05); send_byte(8'hFF);
        checks++;
        if (kx_valid !== 1'b1) begin
            errors++;
            $display("FAIL issue_latency: kx_valid=%b, want 1", kx_valid);
        end
        exp_q.push_back(8'h5A); push_y32(32'd3); push_y32(32'd11);
        core_op({16'hFF05, 32'h04030201}, {17'd11, 17'd3});
        collect(9, -1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_run_end: err=%b busy=%b, want 0/0", err, busy);
        end
    endtask

    task automatic test_rerun();
        send_byte(8'hA3);
        exp_q.push_back(8'h5A); push_y32(32'd3); push_y32(32'd11);
        core_op({16'hFF05, 32'h04030201}, {17'd11, 17'd3});
        collect(9, -1);
    endtask

    task automatic test_bad_opcode();
        send_byte(8'h7E);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_opcode: err=%b busy=%b, want 1/0", err, busy);
        end
        send_byte(8'hA3);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: err=%b busy=%b, want 0/1", err, busy);
        end
        exp_q.push_back(8'h5A); push_y32(32'd5); push_y32(32'd7);
        core_op({16'hFF05, 32'h04030201}, {17'd7, 17'd5});
        collect(9, -1);
    endtask

    task automatic test_timeout();
        send_byte(8'hA1);
        send_byte(8'h01);
        repeat (99) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: busy=%b err=%b after 99 idle, want 1/0", busy, err);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hit: busy=%b err=%b after 100 idle, want 0/1", busy, err);
        end
        send_byte(8'hA1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'hA3);
        exp_q.push_back(8'h5A); push_y32(32'd1); push_y32(32'd2);
        core_op({16'hFF05, 32'h44332211}, {17'd2, 17'd1});
        collect(9, -1);
    endtask

    task automatic test_stall();
        send_byte(8'hA3);
        exp_q.push_back(8'h5A); push_y32(32'hFFFFABCD); push_y32(32'h00000102);
        core_op({16'hFF05, 32'h44332211}, {17'h00102, 17'h1ABCD});
        collect(9, 3);
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA2);
        send_byte(8'h05);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_rx_busy: busy=%b, want 1", busy);
        end
        rstn = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset_outputs");
        rstn = 1'b1;
        @(negedge clk);
        send_byte(8'hA3);
        exp_q.push_back(8'h5A); push_y32(32'd0); push_y32(32'd0);
        core_op('0, '0);
        collect(9, -1);
    endtask

    task automatic test_narrow();
        sel = 1'b1;
        @(negedge clk);
        send_byte(8'hA1);
        for (int i = 0; i < 4; i++) send_byte(8'h80);
        send_byte(8'hA2);
        send_byte(8'h80); send_byte(8'h80);
`ifdef MVM_UART_SAT_EN
        exp_q.push_back(8'h5B); push_y16(16'h7FFF);
`else
        exp_q.push_back(8'h5A); push_y16(16'h8000);
`endif
        push_y16(16'hFFFB);
        core_op({16'h8080, 32'h80808080}, {17'h1FFFB, 17'h08000});
        collect(5, -1);
        sel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_run();
        test_rerun();
        test_bad_opcode();
        test_timeout();
        test_stall();
        test_reset_mid();
        test_narrow();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
